graphic_chart_unit: RTL and testbench

Parametrised chart renderer for one scanline. On start it sweeps dx across LINE_W pixels and fetches one sample per column from the value buffer. It scales and offsets each sample, compares the result against the current row dy, and emits one RGB565 pixel per cycle with wr. It sits beside the string and box units under the graphic compositor and uses the same start/dy/dx/wr/done contract. It adds bar, line and waterfall modes, a pipelined buffer read of configurable latency, and saturating arithmetic.

---
 rtl/graphic_chart_unit_pkg.sv | 38 +++
 rtl/graphic_chart_unit_if.sv | 35 +++
 rtl/graphic_chart_unit_scaler.sv | 40 ++++
 rtl/graphic_chart_unit.sv | 171 +++++++++++++++++
 tb/tb_graphic_chart_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/graphic_chart_unit_pkg.sv
// Shared types for the chart renderer: pixel modes, FSM states and
// RGB565 field helpers.
package graphic_chart_unit_pkg;

  typedef enum logic [1:0] {
    MODE_BAR       = 2'd0,
    MODE_LINE      = 2'd1,
    MODE_WATERFALL = 2'd2,
    MODE_RSVD      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  function automatic logic [4:0] rgbRed(input logic [15:0] px);
    return px[RGB_R_MSB:RGB_R_LSB];
  endfunction

  function automatic logic [5:0] rgbGreen(input logic [15:0] px);
    return px[RGB_G_MSB:RGB_G_LSB];
  endfunction

  function automatic logic [4:0] rgbBlue(input logic [15:0] px);
    return px[RGB_B_MSB:RGB_B_LSB];
  endfunction

endpackage

// File: rtl/graphic_chart_unit_if.sv
// Bus bundle between the compositor (master) and the chart renderer
// (slave), including the value-buffer read port.
interface graphic_chart_unit_if #(
  parameter int COORD_W = 12,
  parameter int VAL_W   = 16,
  parameter int ADDR_W  = 11
);
  logic               start;
  logic [COORD_W-1:0] dy;
  logic [1:0]         mode;
  logic [2:0]         kx;
  logic [ADDR_W-1:0]  bx;
  logic [5:0]         ky;
  logic [COORD_W:0]   by;
  logic [15:0]        color_0;
  logic [15:0]        color_1;
  logic [ADDR_W-1:0]  val_addr;
  logic [VAL_W-1:0]   val_in;
  logic [COORD_W-1:0] dx;
  logic               wr;
  logic [15:0]        data;
  logic               done;
  logic               busy;

  modport master (
    output start, dy, mode, kx, bx, ky, by, color_0, color_1, val_in,
    input  val_addr, dx, wr, data, done, busy
  );

  modport slave (
    input  start, dy, mode, kx, bx, ky, by, color_0, color_1, val_in,
    output val_addr, dx, wr, data, done, busy
  );

endinterface

// File: rtl/graphic_chart_unit_scaler.sv
// Combinational sample scaler: shift by a signed amount, add a signed
// offset and clamp the result into the chart's coordinate range.
module chart_scaler
  import graphic_chart_unit_pkg::*;
#(
  parameter int COORD_W = 12,
  parameter int VAL_W   = 16
) (
  input  logic [VAL_W-1:0]   val_i,
  input  logic [5:0]         ky_i,
  input  logic [COORD_W:0]   by_i,
  output logic [COORD_W-1:0] h_o
);

  localparam int SW   = VAL_W + COORD_W + 8;
  localparam int SUMW = SW + 2;
  localparam logic [SUMW-2:0] HMAX = (SUMW-1)'((1 << COORD_W) - 1);

  logic [SW-1:0]   extVal;
  logic [SW-1:0]   shifted;
  logic [5:0]      kyMag;
  logic [SUMW-1:0] sum;

  // Shift the widened sample, add the sign-extended offset, then clamp;
  // the sum is two bits wider than the shift so its top bit is a true sign.
  always_comb begin
    extVal  = SW'(val_i);
    kyMag   = ky_i[5] ? (~ky_i + 6'd1) : ky_i;
    shifted = ky_i[5] ? (extVal >> kyMag) : (extVal << kyMag);
    sum     = {2'b00, shifted} + {{(SUMW-COORD_W-1){by_i[COORD_W]}}, by_i};
    if (sum[SUMW-1]) begin
      h_o = '0;
    end else if (sum[SUMW-2:0] > HMAX) begin
      h_o = '1;
    end else begin
      h_o = sum[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/graphic_chart_unit.sv
// One-scanline chart renderer: sweeps the columns, reads one buffer
// sample per column through a fixed-latency pipeline and emits one
// RGB565 pixel per cycle in bar, line or waterfall style.
module graphic_chart_unit
  import graphic_chart_unit_pkg::*;
#(
  parameter int COORD_W = 12,
  parameter int VAL_W   = 16,
  parameter int ADDR_W  = 11,
  parameter int LINE_W  = 320,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  graphic_chart_unit_if.slave bus
);

  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(LINE_W - 1);

  state_e             state_q;
  logic [COORD_W-1:0] col_q;
  logic [ADDR_W-1:0]  valAddr_q;
  logic               done_q;

  logic [COORD_W-1:0] dy_q;
  mode_e              mode_q;
  logic [2:0]         kx_q;
  logic [ADDR_W-1:0]  bx_q;
  logic [5:0]         ky_q;
  logic [COORD_W:0]   by_q;
  logic [15:0]        color0_q;
  logic [15:0]        color1_q;

  logic [RD_LAT:0]    vld_q;
  logic [COORD_W-1:0] colPipe_q [RD_LAT+1];
  logic               wr_q;
  logic [COORD_W-1:0] dx_q;
  logic [15:0]        data_q;

  logic               startAccept;
  logic               issueValid;
  logic [COORD_W-1:0] issueCol;
  logic [ADDR_W-1:0]  issueBase;
  logic [ADDR_W-1:0]  valAddr_d;
  logic               lastOut;
  logic [COORD_W-1:0] h;
  logic [15:0]        pix_d;

  chart_scaler #(
    .COORD_W (COORD_W),
    .VAL_W   (VAL_W)
  ) uScaler (
    .val_i (bus.val_in),
    .ky_i  (ky_q),
    .by_i  (by_q),
    .h_o   (h)
  );

  // Decide which column address goes out this cycle; a start that lands
  // while the done pulse is still visible is deliberately refused.
  always_comb begin
    startAccept = (state_q == IDLE) && bus.start && !done_q;
    issueValid  = startAccept || (state_q == RUN);
    issueCol    = (state_q == RUN) ? col_q : '0;
    issueBase   = (state_q == RUN) ? bx_q : bus.bx;
    valAddr_d   = issueBase + ADDR_W'(issueCol >> kx_q);
    lastOut     = vld_q[RD_LAT] && (colPipe_q[RD_LAT] == LAST_COL);
  end

  // Turn the sample arriving this cycle into a pixel colour.
  always_comb begin
    case (mode_q)
      MODE_LINE:      pix_d = (dy_q == h) ? color1_q : color0_q;
      MODE_WATERFALL: pix_d = 16'(bus.val_in);
      default:        pix_d = (dy_q < h) ? color1_q : color0_q;
    endcase
  end

  // Line sequencer: latches the job on start, walks the columns, waits
  // for the pipeline to drain and pulses done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      valAddr_q <= '0;
      done_q    <= 1'b0;
      dy_q      <= '0;
      mode_q    <= MODE_BAR;
      kx_q      <= '0;
      bx_q      <= '0;
      ky_q      <= '0;
      by_q      <= '0;
      color0_q  <= '0;
      color1_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startAccept) begin
            dy_q      <= bus.dy;
            mode_q    <= mode_e'(bus.mode);
            kx_q      <= bus.kx;
            bx_q      <= bus.bx;
            ky_q      <= bus.ky;
            by_q      <= bus.by;
            color0_q  <= bus.color_0;
            color1_q  <= bus.color_1;
            valAddr_q <= valAddr_d;
            if (LINE_W == 1) begin
              state_q <= FLUSH;
            end else begin
              state_q <= RUN;
              col_q   <= COORD_W'(1);
            end
          end
        end
        RUN: begin
          valAddr_q <= valAddr_d;
          if (col_q == LAST_COL) begin
            state_q <= FLUSH;
          end else begin
            col_q <= col_q + COORD_W'(1);
          end
        end
        FLUSH: begin
          if (lastOut) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-latency pipeline carrying the column index alongside the valid
  // bit, and the registered pixel outputs at its end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        colPipe_q[i] <= '0;
      end
      wr_q   <= 1'b0;
      dx_q   <= '0;
      data_q <= '0;
    end else begin
      vld_q        <= {vld_q[RD_LAT-1:0], issueValid};
      colPipe_q[0] <= issueCol;
      for (int i = 1; i <= RD_LAT; i++) begin
        colPipe_q[i] <= colPipe_q[i-1];
      end
      wr_q <= vld_q[RD_LAT];
      if (vld_q[RD_LAT]) begin
        dx_q   <= colPipe_q[RD_LAT];
        data_q <= pix_d;
      end
    end
  end

  assign bus.val_addr = valAddr_q;
  assign bus.dx       = dx_q;
  assign bus.wr       = wr_q;
  assign bus.data     = data_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_graphic_chart_unit.sv
// Bench for the chart renderer: a table of directed lines, a few
// hand-built handshake/reset sequences and random lines, all compared
// against an arithmetic reference of the pixel rules.
module tb_graphic_chart_unit;
  import graphic_chart_unit_pkg::*;

  localparam int COORD_W = 12;
  localparam int VAL_W   = 16;
  localparam int ADDR_W  = 11;
  localparam int LINE_W  = 320;
  localparam int RD_LAT  = 1;
  localparam logic [15:0] C0 = 16'h001F;
  localparam logic [15:0] C1 = 16'hF800;

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  kx;
    logic [10:0] bx;
    logic [5:0]  ky;
    logic [12:0] by;
    logic [11:0] dy;
    logic [15:0] c0;
    logic [15:0] c1;
  } cfg_t;

  typedef struct {
    string name;
    cfg_t  c;
    int    fillKind;
    int    fillVal;
    int    expFg;
  } vec_t;

  typedef struct {
    int firstWr;
    int doneK;
    int wrCount;
    int fgCount;
    int pixErr;
    int addrErr;
    int dxErr;
    int busyErr;
    int doneCount;
    int busyAfter;
  } stats_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  graphic_chart_unit_if #(.COORD_W(COORD_W), .VAL_W(VAL_W), .ADDR_W(ADDR_W)) bus();

  graphic_chart_unit #(
    .COORD_W (COORD_W),
    .VAL_W   (VAL_W),
    .ADDR_W  (ADDR_W),
    .LINE_W  (LINE_W),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [2048];
  logic [15:0] rdPipe [RD_LAT];

  // Value buffer with a read latency of RD_LAT clocks.
  always @(posedge clk) begin
    rdPipe[0] <= mem[bus.val_addr];
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign bus.val_in = rdPipe[RD_LAT-1];

  function automatic cfg_t mkCfg(int mode, int kx, int bx, int ky, int by, int dy,
                                 logic [15:0] c0, logic [15:0] c1);
    cfg_t c;
    c.mode = 2'(mode);
    c.kx   = 3'(kx);
    c.bx   = 11'(bx);
    c.ky   = 6'(ky);
    c.by   = 13'(by);
    c.dy   = 12'(dy);
    c.c0   = c0;
    c.c1   = c1;
    return c;
  endfunction

  function automatic int scaleRef(int v, logic [5:0] ky, logic [12:0] by);
    int     k;
    longint s;
    longint b;
    longint hh;
    k = ky[5] ? int'(ky) - 64 : int'(ky);
    if (k >= 0) s = (longint'(v) << k) & 64'h0000_000F_FFFF_FFFF;
    else        s = longint'(v) >> (-k);
    b  = by[12] ? longint'(by) - 8192 : longint'(by);
    hh = s + b;
    if (hh < 0)    return 0;
    if (hh > 4095) return 4095;
    return int'(hh);
  endfunction

  function automatic int expAddr(cfg_t c, int x);
    return (int'(c.bx) + (x >> c.kx)) % 2048;
  endfunction

  function automatic logic [15:0] expPixel(cfg_t c, int x);
    int v;
    int h;
    v = int'(mem[expAddr(c, x)]);
    if (c.mode == 2'd2) return 16'(v);
    h = scaleRef(v, c.ky, c.by);
    if (c.mode == 2'd1) return (int'(c.dy) == h) ? c.c1 : c.c0;
    return (int'(c.dy) < h) ? c.c1 : c.c0;
  endfunction

  function automatic void fillMem(int kind, int val);
    for (int i = 0; i < 2048; i++) mem[i] = (kind == 0) ? 16'(val) : 16'(val + i);
  endfunction

  task automatic drive(cfg_t c);
    bus.mode = c.mode; bus.kx = c.kx; bus.bx = c.bx; bus.ky = c.ky;
    bus.by = c.by; bus.dy = c.dy; bus.color_0 = c.c0; bus.color_1 = c.c1;
  endtask

  task automatic scramble();
    bus.mode = 2'($urandom); bus.kx = 3'($urandom); bus.bx = 11'($urandom);
    bus.ky = 6'($urandom); bus.by = 13'($urandom); bus.dy = 12'($urandom);
    bus.color_0 = 16'($urandom); bus.color_1 = 16'($urandom);
  endtask

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Run one line and gather what the DUT did, cycle by cycle.
  task automatic applyStimulus(input cfg_t c, input bit pokeStart, input bit startAtDone,
                               output stats_t st);
    int budget;
    budget = LINE_W + RD_LAT + 12;
    st = '{firstWr: -1, doneK: -1, default: 0};
    @(negedge clk);
    drive(c);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
    for (int k = 0; k < budget; k++) begin
      if (k < LINE_W && int'(bus.val_addr) != expAddr(c, k)) st.addrErr++;
      if (bus.wr) begin
        if (st.firstWr < 0) st.firstWr = k;
        if (int'(bus.dx) != st.wrCount) st.dxErr++;
        if (bus.data !== expPixel(c, st.wrCount)) st.pixErr++;
        if (bus.data == c.c1) st.fgCount++;
        if (!bus.busy) st.busyErr++;
        st.wrCount++;
      end
      if (bus.done) begin
        st.doneCount++;
        if (st.doneK < 0) st.doneK = k;
        if (bus.busy) st.busyErr++;
      end
      bus.start = (pokeStart && k == 49) || (startAtDone && bus.done);
      @(posedge clk);
      #1;
    end
    st.busyAfter = int'(bus.busy);
    bus.start = 1'b0;
  endtask

  task automatic checkLine(string name, stats_t st, int expFg);
    checkOutput({name, "_first_wr"}, st.firstWr, RD_LAT + 1);
    checkOutput({name, "_wr_count"}, st.wrCount, LINE_W);
    checkOutput({name, "_done_gap"}, st.doneK - st.firstWr, LINE_W);
    checkOutput({name, "_done_pulses"}, st.doneCount, 1);
    checkOutput({name, "_bad_pixels"}, st.pixErr, 0);
    checkOutput({name, "_bad_addr"}, st.addrErr, 0);
    checkOutput({name, "_bad_dx"}, st.dxErr, 0);
    checkOutput({name, "_busy"}, st.busyErr, 0);
    checkOutput({name, "_busy_after"}, st.busyAfter, 0);
    if (expFg >= 0) checkOutput({name, "_fg_count"}, st.fgCount, expFg);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t   vecs[$];
    stats_t st;
    cfg_t   c;

    vecs.push_back('{"bar49",       mkCfg(0, 0, 0,    0,    0,   49, C0, C1),        0, 50,      320});
    vecs.push_back('{"bar50",       mkCfg(0, 0, 0,    0,    0,   50, C0, C1),        0, 50,      0});
    vecs.push_back('{"rsvd49",      mkCfg(3, 0, 0,    0,    0,   49, C0, C1),        0, 50,      320});
    vecs.push_back('{"line_ramp",   mkCfg(1, 1, 10,   0,    0,   30, C0, C1),        1, 0,       2});
    vecs.push_back('{"line_sat",    mkCfg(1, 0, 0,    5,    0, 4095, C0, C1),        0, 'hFFFF,  320});
    vecs.push_back('{"bar_sat_max", mkCfg(0, 0, 0,    5,    0, 4095, C0, C1),        0, 'hFFFF,  0});
    vecs.push_back('{"bar_sat_4094",mkCfg(0, 0, 0,    5,    0, 4094, C0, C1),        0, 'hFFFF,  320});
    vecs.push_back('{"bar_clamp0",  mkCfg(0, 0, 0,   -3, -100,    0, C0, C1),        0, 16,      0});
    vecs.push_back('{"line_offset", mkCfg(1, 0, 0,    1,  -40,  160, C0, C1),        0, 100,     320});
    vecs.push_back('{"waterfall",   mkCfg(2, 0, 0,    0,    0,    0, C0, 16'h07E0),  1, 'hF800,  0});
    vecs.push_back('{"addr_wrap",   mkCfg(0, 0, 2040, 0,    0,    5, C0, C1),        1, 0,       314});

    bus.start = 1'b0;
    drive(mkCfg(0, 0, 0, 0, 0, 0, C0, C1));
    fillMem(0, 0);

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_wr", int'(bus.wr), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_val_addr", int'(bus.val_addr), 0);
    checkOutput("reset_dx", int'(bus.dx), 0);
    checkOutput("reset_data", int'(bus.data), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      $display("[TB] line %s", vecs[i].name);
      fillMem(vecs[i].fillKind, vecs[i].fillVal);
      applyStimulus(vecs[i].c, 1'b0, 1'b0, st);
      checkLine(vecs[i].name, st, vecs[i].expFg);
    end

    // Reset in the middle of a line, then a clean full line.
    fillMem(0, 50);
    c = mkCfg(0, 0, 0, 0, 0, 49, C0, C1);
    @(negedge clk);
    drive(c);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("midline_wr_before_reset", int'(bus.wr), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midline_reset_wr", int'(bus.wr), 0);
    checkOutput("midline_reset_done", int'(bus.done), 0);
    checkOutput("midline_reset_busy", int'(bus.busy), 0);
    checkOutput("midline_reset_val_addr", int'(bus.val_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(c, 1'b0, 1'b0, st);
    checkLine("after_reset", st, 320);

    // A start pulsed while busy must not restart the line.
    applyStimulus(c, 1'b1, 1'b0, st);
    checkLine("start_while_busy", st, 320);

    // A start coinciding with done must be ignored.
    applyStimulus(c, 1'b0, 1'b1, st);
    checkLine("start_at_done", st, 320);

    // Random lines against the reference rules.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
      if (r % 2 == 0) for (int i = 0; i < 2048; i++) mem[i] = mem[i] & 16'h0FFF;
      c = mkCfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 2047)), int'($urandom_range(0, 10)) - 8,
                int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 4095)),
                16'($urandom), 16'($urandom));
      $display("[TB] random line %0d mode %0d", r, c.mode);
      applyStimulus(c, 1'b0, 1'b0, st);
      checkLine($sformatf("random%0d", r), st, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
